// File: rtl/buzzer_tone_driver.sv
// buzzer_tone_driver: gated 50%-duty square-wave tone generator with glitch-free pitch changes
module buzzer_tone_driver #(
  parameter int CLK_HZ = 100_000_000,
  parameter int HALF_W = 19
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iRing,
  input  logic [3:0] iNote,
  input  logic [1:0] iOctave,
  output logic       oBuzz,
  output logic       oPlaying,
  output logic [3:0] oNoteLatched
);
  typedef enum logic [1:0] {IDLE, PLAY, STOP} state_t;
  function automatic logic [HALF_W-1:0] mid_half(input longint f_mhz);
    logic [63:0] h;
    h = (64'(CLK_HZ) * 64'd1000) / (64'd2 * 64'(f_mhz));
    return h[HALF_W-1:0];
  endfunction
  localparam logic [HALF_W-1:0] MID [8] = '{
    '0, mid_half(261626), mid_half(293665), mid_half(329628),
    mid_half(349228), mid_half(391995), mid_half(440000), mid_half(493883)
  };
  function automatic logic [HALF_W-1:0] half_sel(input logic [3:0] n, input logic [1:0] o);
    logic [HALF_W-1:0] m;
    m = MID[n[2:0]];
    return o == 2'd0 ? m << 1 : o == 2'd2 ? m >> 1 : m;
  endfunction
  state_t            state;
  logic [HALF_W-1:0] cnt, half, pend_half;
  logic [3:0]        pend_note;
  logic [1:0]        oct_l, pend_oct;
  logic              pend, valid, wrap, stop_req;
  assign valid    = iNote != 4'd0 && iNote < 4'd8;
  assign wrap     = cnt == half - 1'b1;
  assign stop_req = !iRing || !valid;
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      half         <= '0;
      oBuzz        <= 1'b0;
      oPlaying     <= 1'b0;
      oNoteLatched <= 4'd0;
      oct_l        <= 2'd0;
      pend         <= 1'b0;
      pend_note    <= 4'd0;
      pend_oct     <= 2'd0;
      pend_half    <= '0;
    end else begin
      case (state)
        IDLE: begin
          pend <= 1'b0;
          if (iRing && valid) begin
            state        <= PLAY;
            half         <= half_sel(iNote, iOctave);
            oNoteLatched <= iNote;
            oct_l        <= iOctave;
            oBuzz        <= 1'b1;
            oPlaying     <= 1'b1;
            cnt          <= '0;
          end
        end
        PLAY: begin
          // a stop during the low phase, or on the last high cycle, must not open a new high phase
          if (stop_req && (!oBuzz || wrap)) begin
            state        <= IDLE;
            cnt          <= '0;
            half         <= '0;
            oBuzz        <= 1'b0;
            oPlaying     <= 1'b0;
            oNoteLatched <= 4'd0;
            pend         <= 1'b0;
          end else if (stop_req) begin
            state <= STOP;
            cnt   <= cnt + 1'b1;
          end else begin
            pend      <= iNote != oNoteLatched || iOctave != oct_l;
            pend_note <= iNote;
            pend_oct  <= iOctave;
            pend_half <= half_sel(iNote, iOctave);
            if (wrap) begin
              cnt   <= '0;
              oBuzz <= !oBuzz;
              if (!oBuzz && pend) begin
                half         <= pend_half;
                oNoteLatched <= pend_note;
                oct_l        <= pend_oct;
                pend         <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (wrap) begin
            state        <= IDLE;
            cnt          <= '0;
            half         <= '0;
            oBuzz        <= 1'b0;
            oPlaying     <= 1'b0;
            oNoteLatched <= 4'd0;
            pend         <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buzzer_tone_driver.sv
// tb_buzzer_tone_driver: directed table-driven check of tone pitch, gating, pitch switch and reset
module tb_buzzer_tone_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ring = 1'b0;
  logic [3:0] note = 4'd0;
  logic [1:0] oct = 2'd1;
  logic       buzz, playing;
  logic [3:0] latched;
  int tests = 0;
  int fails = 0;
  buzzer_tone_driver #(.CLK_HZ(1_000_000), .HALF_W(19)) dut (
    .iClk(clk), .iReset_n(rst_n), .iRing(ring), .iNote(note), .iOctave(oct),
    .oBuzz(buzz), .oPlaying(playing), .oNoteLatched(latched)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] note;
    logic [1:0] oct;
    int         half;
    logic       play;
  } vec_t;
  vec_t vecs [10];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic start(input logic [3:0] n, input logic [1:0] o);
    rst_n = 1'b0;
    ring = 1'b0;
    repeat (2) @(negedge clk);
    note = n;
    oct = o;
    ring = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic phase(input logic lvl, input int drop_at, input int sw_at,
                       input logic [3:0] sw_note, output int n);
    n = 1;
    while (n < 10000) begin
      if (n == drop_at) ring = 1'b0;
      if (n == sw_at) note = sw_note;
      @(negedge clk);
      if (buzz != lvl) break;
      n++;
    end
  endtask
  initial begin
    int n;
    int bad;
    vecs[0] = '{4'd6, 2'd1, 1136, 1'b1};
    vecs[1] = '{4'd1, 2'd0, 3822, 1'b1};
    vecs[2] = '{4'd1, 2'd1, 1911, 1'b1};
    vecs[3] = '{4'd1, 2'd2, 955,  1'b1};
    vecs[4] = '{4'd1, 2'd3, 1911, 1'b1};
    vecs[5] = '{4'd2, 2'd1, 1702, 1'b1};
    vecs[6] = '{4'd7, 2'd2, 506,  1'b1};
    vecs[7] = '{4'd0, 2'd1, 0,    1'b0};
    vecs[8] = '{4'd9, 2'd1, 0,    1'b0};
    vecs[9] = '{4'd15, 2'd2, 0,   1'b0};
    repeat (3) @(negedge clk);
    chk("reset_buzz", buzz, 0);
    chk("reset_playing", playing, 0);
    chk("reset_latched", latched, 0);
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].note, vecs[i].oct);
      chk($sformatf("v%0d_buzz_first", i), buzz, vecs[i].play);
      chk($sformatf("v%0d_playing", i), playing, vecs[i].play);
      chk($sformatf("v%0d_latched", i), latched, vecs[i].play ? vecs[i].note : 0);
      if (vecs[i].play) begin
        phase(1'b1, 0, 0, 4'd0, n);
        chk($sformatf("v%0d_high_len", i), n, vecs[i].half);
        phase(1'b0, 0, 0, 4'd0, n);
        chk($sformatf("v%0d_low_len", i), n, vecs[i].half);
      end else begin
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (buzz || playing) bad++;
        end
        chk($sformatf("v%0d_silent", i), bad, 0);
      end
    end
    start(4'd6, 2'd1);
    phase(1'b1, 0, 500, 4'd1, n);
    chk("sw_cur_high", n, 1136);
    chk("sw_latched_low", latched, 6);
    phase(1'b0, 0, 0, 4'd0, n);
    chk("sw_cur_low", n, 1136);
    chk("sw_latched_new", latched, 1);
    phase(1'b1, 0, 0, 4'd0, n);
    chk("sw_new_high", n, 1911);
    phase(1'b0, 0, 0, 4'd0, n);
    chk("sw_new_low", n, 1911);
    start(4'd6, 2'd1);
    phase(1'b1, 300, 0, 4'd0, n);
    chk("drop_high_len", n, 1136);
    chk("drop_high_playing", playing, 0);
    chk("drop_high_latched", latched, 0);
    bad = 0;
    ring = 1'b1;
    ring = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (buzz || playing) bad++;
    end
    chk("drop_high_idle", bad, 0);
    start(4'd6, 2'd1);
    phase(1'b1, 0, 0, 4'd0, n);
    chk("drop_low_high_len", n, 1136);
    repeat (1135) @(negedge clk);
    chk("drop_low_still_play", playing, 1);
    ring = 1'b0;
    @(negedge clk);
    chk("drop_low_buzz", buzz, 0);
    chk("drop_low_playing", playing, 0);
    chk("drop_low_latched", latched, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (buzz) bad++;
    end
    chk("drop_low_no_pulse", bad, 0);
    start(4'd0, 2'd1);
    repeat (20) @(negedge clk);
    chk("rest_buzz", buzz, 0);
    note = 4'd9;
    repeat (20) @(negedge clk);
    chk("inv_playing", playing, 0);
    note = 4'd3;
    @(negedge clk);
    chk("late_valid_buzz", buzz, 1);
    chk("late_valid_latched", latched, 3);
    start(4'd6, 2'd1);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_buzz", buzz, 0);
    chk("midrst_playing", playing, 0);
    chk("midrst_latched", latched, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_buzz", buzz, 1);
    chk("restart_latched", latched, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
